// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline controller.
package pipe_pkg;
  localparam int REG_AW = 5;
  typedef logic [REG_AW-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
  typedef enum logic [1:0] {WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC4 = 2'b10} wb_src_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_e;
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     we;
    wb_src_e  src;
  } ctrl_tok_t;
  typedef struct packed {
    ctrl_tok_t tok;
    reg_idx_t  rs1;
    reg_idx_t  rs2;
    logic      use1;
    logic      use2;
  } ex_tok_t;
  function automatic logic eff_wr(input ctrl_tok_t t);
    return t.valid & t.we & (t.rd != REG_ZERO);
  endfunction
  // PC4 results are only forwarded once they reach WB
  function automatic fwd_e fwd_sel(input logic use_rs, input reg_idx_t rs, input ctrl_tok_t mem, input ctrl_tok_t wb);
    return (use_rs & eff_wr(mem) & (mem.rd == rs) & (mem.src == WB_ALU)) ? FWD_MEM :
           (use_rs & eff_wr(wb) & (wb.rd == rs)) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: combinational load-use, redirect and forwarding decisions.
module pipe_hazard_unit
  import pipe_pkg::*;
(
  input  ex_tok_t   ex_i,
  input  ctrl_tok_t mem_i,
  input  ctrl_tok_t wb_i,
  input  logic      id_valid_i,
  input  reg_idx_t  id_rs1_i,
  input  reg_idx_t  id_rs2_i,
  input  logic      id_use_rs1_i,
  input  logic      id_use_rs2_i,
  input  logic      ex_redirect_i,
  output logic      redirect_o,
  output logic      stall_o,
  output fwd_e      fwd_a_o,
  output fwd_e      fwd_b_o
);
  logic hazard;
  assign redirect_o = ex_redirect_i & ex_i.tok.valid;
  assign hazard = eff_wr(ex_i.tok) & (ex_i.tok.src == WB_MEM) & id_valid_i &
                  ((id_use_rs1_i & (id_rs1_i == ex_i.tok.rd)) | (id_use_rs2_i & (id_rs2_i == ex_i.tok.rd)));
  assign stall_o = hazard & ~redirect_o;
  assign fwd_a_o = fwd_sel(ex_i.use1, ex_i.rs1, mem_i, wb_i);
  assign fwd_b_o = fwd_sel(ex_i.use2, ex_i.rs2, mem_i, wb_i);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: shadow control-token pipeline (EX/MEM/WB) with hazard, forwarding,
// write-back select generation and performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [RF_AW-1:0] id_rs1_i,
  input  logic [RF_AW-1:0] id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [RF_AW-1:0] id_rd_i,
  input  logic             id_we_i,
  input  logic [1:0]       id_wb_src_i,
  input  logic             ex_redirect_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             wb_sel1_o,
  output logic             wb_sel2_o,
  output logic             pc_sel_o,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_rd_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  ex_tok_t ex_q, ex_d;
  ctrl_tok_t mem_q, wb_q;
  logic [CNT_W-1:0] instret_q, stall_cnt_q;
  logic redirect, stall;
  fwd_e fwd_a, fwd_b;
  pipe_hazard_unit u_hazard (
    .ex_i         (ex_q),
    .mem_i        (mem_q),
    .wb_i         (wb_q),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .ex_redirect_i(ex_redirect_i),
    .redirect_o   (redirect),
    .stall_o      (stall),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b)
  );
  // a squashed or stalled ID slot enters EX as an all-zero bubble
  assign ex_d = (redirect | stall) ? '0 : ex_tok_t'{
    tok: ctrl_tok_t'{valid: id_valid_i, rd: id_rd_i, we: id_we_i, src: wb_src_e'(id_wb_src_i)},
    rs1: id_rs1_i, rs2: id_rs2_i, use1: id_use_rs1_i, use2: id_use_rs2_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q.tok;
      wb_q        <= mem_q;
      instret_q   <= instret_q + CNT_W'(wb_q.valid);
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
    end
  end
  assign stall_o     = stall;
  assign flush_o     = redirect;
  assign pc_sel_o    = ~redirect;
  assign fwd_a_o     = fwd_a;
  assign fwd_b_o     = fwd_b;
  assign wb_sel1_o   = ~wb_q.valid | (wb_q.src == WB_ALU);
  assign wb_sel2_o   = ~wb_q.valid | (wb_q.src != WB_PC4);
  assign rf_we_o     = eff_wr(wb_q);
  assign rf_rd_o     = wb_q.valid ? wb_q.rd : REG_ZERO;
  assign instret_o   = instret_q;
  assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against an instruction-level model.
module tb_pipe_ctrl;
  logic clk = 0, rst;
  logic id_valid_i, id_use_rs1_i, id_use_rs2_i, id_we_i, ex_redirect_i;
  logic [4:0] id_rs1_i, id_rs2_i, id_rd_i, rf_rd_o;
  logic [1:0] id_wb_src_i, fwd_a_o, fwd_b_o;
  logic stall_o, flush_o, wb_sel1_o, wb_sel2_o, pc_sel_o, rf_we_o;
  logic [3:0] instret_o, stall_cnt_o;
  int checks = 0, failures = 0;

  pipe_ctrl #(.CNT_W(4), .RF_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .id_rd_i(id_rd_i), .id_we_i(id_we_i),
    .id_wb_src_i(id_wb_src_i), .ex_redirect_i(ex_redirect_i), .stall_o(stall_o), .flush_o(flush_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .wb_sel1_o(wb_sel1_o), .wb_sel2_o(wb_sel2_o),
    .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .instret_o(instret_o),
    .stall_cnt_o(stall_cnt_o));

  always #5 clk = ~clk;

  // instruction record: src 0=load, 1=alu, 2=pc+4
  typedef struct {bit v; bit we; bit u1; bit u2; int rd; int rs1; int rs2; int src;} ins_t;
  ins_t m_ex, m_mem, m_wb, nop_ins;
  int m_instret = 0, m_stall = 0;

  function automatic bit writes(ins_t t);
    return t.v && t.we && t.rd != 0;
  endfunction
  function automatic int exp_fwd(bit u, int r);
    if (u && writes(m_mem) && m_mem.rd == r && m_mem.src == 1) return 1;
    if (u && writes(m_wb) && m_wb.rd == r) return 2;
    return 0;
  endfunction
  function automatic bit exp_redirect();
    return ex_redirect_i && m_ex.v;
  endfunction
  function automatic bit exp_stall();
    bit uses_load = writes(m_ex) && m_ex.src == 0 && id_valid_i &&
      ((id_use_rs1_i && int'(id_rs1_i) == m_ex.rd) || (id_use_rs2_i && int'(id_rs2_i) == m_ex.rd));
    return uses_load && !exp_redirect();
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit we, int src, bit redir);
    id_valid_i = v; id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2); id_use_rs1_i = u1; id_use_rs2_i = u2;
    id_rd_i = 5'(rd); id_we_i = we; id_wb_src_i = 2'(src); ex_redirect_i = redir;
  endtask

  task automatic settle();
    @(negedge clk);
    chk("stall", stall_o, exp_stall());
    chk("flush", flush_o, exp_redirect());
    chk("pc_sel", pc_sel_o, !exp_redirect());
    chk("fwd_a", fwd_a_o, exp_fwd(m_ex.u1, m_ex.rs1));
    chk("fwd_b", fwd_b_o, exp_fwd(m_ex.u2, m_ex.rs2));
    chk("wb_sel1", wb_sel1_o, !m_wb.v || m_wb.src == 1);
    chk("wb_sel2", wb_sel2_o, !m_wb.v || m_wb.src != 2);
    chk("rf_we", rf_we_o, writes(m_wb));
    chk("rf_rd", rf_rd_o, m_wb.v ? m_wb.rd : 0);
    chk("instret", instret_o, m_instret % 16);
    chk("stall_cnt", stall_cnt_o, m_stall % 16);
  endtask

  task automatic tick();
    ins_t id;
    bit kill;
    @(posedge clk);
    if (rst) begin
      m_ex = nop_ins; m_mem = nop_ins; m_wb = nop_ins; m_instret = 0; m_stall = 0;
    end else begin
      kill = exp_redirect() || exp_stall();
      m_stall += int'(exp_stall());
      m_instret += int'(m_wb.v);
      id = '{v: id_valid_i, we: id_we_i, u1: id_use_rs1_i, u2: id_use_rs2_i,
             rd: int'(id_rd_i), rs1: int'(id_rs1_i), rs2: int'(id_rs2_i), src: int'(id_wb_src_i)};
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = kill ? nop_ins : id;
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    nop_ins = '{default: 0};
    m_ex = nop_ins; m_mem = nop_ins; m_wb = nop_ins;
    rst = 1;
    drv(1, 0, 0, 0, 0, 10, 1, 1, 0);
    @(posedge clk); #1;
    settle(); chk("rst_instret", instret_o, 0); tick();
    settle(); chk("rst_rf_we", rf_we_o, 0); chk("rst_fwd_a", fwd_a_o, 0); tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, 0, 0, 0, 10 + i, 1, 1, 0);
      step();
    end
    settle(); chk("run_instret", instret_o, 2); tick();
    // back-to-back ALU dependency
    drv(1, 1, 2, 1, 1, 5, 1, 1, 0); step();
    drv(1, 5, 6, 1, 0, 8, 1, 1, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("alu_fwd_mem", fwd_a_o, 1); tick();
    // dependency with one independent instruction between
    drv(1, 1, 2, 1, 1, 5, 1, 1, 0); step();
    drv(1, 1, 2, 0, 0, 9, 1, 1, 0); step();
    drv(1, 5, 6, 1, 0, 8, 1, 1, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("alu_fwd_wb", fwd_a_o, 2); tick();
    // load-use costs exactly one bubble
    drv(1, 1, 2, 1, 0, 7, 1, 0, 0); step();
    drv(1, 3, 7, 1, 1, 11, 1, 1, 0);
    settle(); chk("lu_stall", stall_o, 1); tick();
    settle(); chk("lu_release", stall_o, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("lu_fwd_b", fwd_b_o, 2); chk("lu_cnt", stall_cnt_o, 1); tick();
    drv(1, 1, 2, 1, 0, 0, 1, 0, 0); step();
    drv(1, 3, 0, 1, 1, 11, 1, 1, 0);
    settle(); chk("lu_x0", stall_o, 0); tick();
    // redirect beats load-use stall
    drv(1, 1, 2, 1, 0, 7, 1, 0, 0); step();
    drv(1, 7, 2, 1, 0, 12, 1, 1, 1);
    settle(); chk("rd_stall", stall_o, 0); chk("rd_flush", flush_o, 1); chk("rd_pc_sel", pc_sel_o, 0); tick();
    settle(); chk("rd_squashed", flush_o, 0); tick();
    // jal writes PC+4 to x1
    drv(1, 0, 0, 0, 0, 1, 1, 2, 0); step();
    drv(1, 2, 3, 1, 1, 13, 1, 1, 1);
    settle(); chk("jal_flush", flush_o, 1); chk("jal_pc_sel", pc_sel_o, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    settle(); chk("jal_sel2", wb_sel2_o, 0); chk("jal_we", rf_we_o, 1); chk("jal_rd", rf_rd_o, 1); tick();
    // load result write-back decode
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    settle(); chk("ld_sel1", wb_sel1_o, 0); chk("ld_sel2", wb_sel2_o, 1); chk("ld_we", rf_we_o, 1); tick();
    step(); step();
    settle(); chk("inv_we", rf_we_o, 0); tick();
    // random traffic with occasional mid-flight reset
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom % 5) != 0;
      rst = ($urandom % 60) == 0;
      drv(v, $urandom % 4, $urandom % 4, v & $urandom % 2, v & $urandom % 2, $urandom % 4,
          v & ($urandom % 4 != 0), $urandom % 3, ($urandom % 7) == 0);
      step();
    end
    // 17 retirements wrap a 4-bit counter to 1
    rst = 1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      drv(1, 0, 0, 0, 0, 1 + i % 8, 1, 1, 0);
      step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    settle(); chk("wrap", instret_o, 1); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
